// File: rtl/csr_bus_pkg.sv
// Shared types and address-field layout for the CSR bus responder.
// Address layout, MSB to LSB: {bit_mode, reg_index, bit_index}.
package csr_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_STROBE,
    RD_CAPTURE
  } state_t;

  localparam int BIT_INDEX_LSB  = 0;
  localparam int BIT_MODE_WIDTH = 1;
  localparam int ERR_READBACK   = 0;

  function automatic int reg_index_lsb(input int bidx_w);
    return BIT_INDEX_LSB + bidx_w;
  endfunction

  function automatic int bit_mode_pos(input int ridx_w, input int bidx_w);
    return reg_index_lsb(bidx_w) + ridx_w;
  endfunction

  function automatic int addr_width(input int ridx_w, input int bidx_w);
    return BIT_MODE_WIDTH + ridx_w + bidx_w;
  endfunction

endpackage

// File: rtl/csr_read_mux.sv
// Combinational read selection from the flattened register bank outputs.
// Indices beyond the bank return the error readback value and raise range_err.
module csr_read_mux
  import csr_bus_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 32,
  parameter int RIDX_W   = $clog2(NUM_REGS),
  parameter int BIDX_W   = $clog2(WIDTH)
) (
  input  logic [NUM_REGS*WIDTH-1:0] csr_q_all,
  input  logic [RIDX_W-1:0]         reg_index,
  input  logic                      bit_mode,
  input  logic [BIDX_W-1:0]         bit_index,
  output logic [WIDTH-1:0]          read_word,
  output logic                      range_err
);

  logic [WIDTH-1:0] selected;

  always_comb begin
    selected  = '0;
    range_err = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_index == RIDX_W'(i)) begin
        selected  = csr_q_all[i*WIDTH +: WIDTH];
        range_err = 1'b0;
      end
    end
    if (range_err) begin
      read_word = WIDTH'(ERR_READBACK);
    end else if (bit_mode) begin
      read_word = WIDTH'(selected[bit_index]);
    end else begin
      read_word = selected;
    end
  end

endmodule

// File: rtl/csr_bus_responder.sv
// Avalon-MM slave fronting a bank of register_csr-style registers: word/bit
// writes become one-cycle active-low load strobes, reads return after two cycles.
module csr_bus_responder
  import csr_bus_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 32,
  parameter int RIDX_W   = $clog2(NUM_REGS),
  parameter int BIDX_W   = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RIDX_W+BIDX_W:0]    avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [WIDTH-1:0]          avs_writedata,
  output logic                      avs_waitrequest,
  output logic [WIDTH-1:0]          avs_readdata,
  output logic                      avs_readdatavalid,
  output logic [WIDTH-1:0]          csr_d_all,
  output logic                      csr_d_bit,
  output logic [BIDX_W-1:0]         csr_bit_address,
  output logic [NUM_REGS-1:0]       csr_load_all_n,
  output logic [NUM_REGS-1:0]       csr_load_bit_n,
  input  logic [NUM_REGS*WIDTH-1:0] csr_q_all,
  output logic                      addr_err
);

  localparam int REG_LSB  = reg_index_lsb(BIDX_W);
  localparam int MODE_POS = bit_mode_pos(RIDX_W, BIDX_W);
  localparam int ADDR_W   = addr_width(RIDX_W, BIDX_W);

  state_t state;

  logic [BIDX_W-1:0]   live_bit;
  logic [RIDX_W-1:0]   live_reg;
  logic                live_mode;
  logic [BIDX_W-1:0]   lat_bit;
  logic [RIDX_W-1:0]   lat_reg;
  logic                lat_mode;
  logic [BIDX_W-1:0]   mux_bit;
  logic [RIDX_W-1:0]   mux_reg;
  logic                mux_mode;
  logic [WIDTH-1:0]    mux_word;
  logic                mux_err;
  logic [NUM_REGS-1:0] reg_onehot;
  logic [ADDR_W-1:0]   addr;

  assign addr      = avs_address;
  assign live_bit  = addr[BIT_INDEX_LSB +: BIDX_W];
  assign live_reg  = addr[REG_LSB +: RIDX_W];
  assign live_mode = addr[MODE_POS];

  assign avs_waitrequest = (state != IDLE) || reset;

  // The single mux range-checks the live address at acceptance and reads the
  // latched address during capture.
  assign mux_bit  = (state == RD_CAPTURE) ? lat_bit  : live_bit;
  assign mux_reg  = (state == RD_CAPTURE) ? lat_reg  : live_reg;
  assign mux_mode = (state == RD_CAPTURE) ? lat_mode : live_mode;

  csr_read_mux #(
    .NUM_REGS(NUM_REGS),
    .WIDTH   (WIDTH),
    .RIDX_W  (RIDX_W),
    .BIDX_W  (BIDX_W)
  ) u_read_mux (
    .csr_q_all(csr_q_all),
    .reg_index(mux_reg),
    .bit_mode (mux_mode),
    .bit_index(mux_bit),
    .read_word(mux_word),
    .range_err(mux_err)
  );

  // Out-of-range indices decode to no bit set, so no strobe ever fires for them.
  always_comb begin
    reg_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (live_reg == RIDX_W'(i)) begin
        reg_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      csr_d_all         <= '0;
      csr_d_bit         <= 1'b0;
      csr_bit_address   <= '0;
      csr_load_all_n    <= '1;
      csr_load_bit_n    <= '1;
      addr_err          <= 1'b0;
      lat_bit           <= '0;
      lat_reg           <= '0;
      lat_mode          <= 1'b0;
    end else begin
      csr_load_all_n    <= '1;
      csr_load_bit_n    <= '1;
      addr_err          <= 1'b0;
      avs_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          // Write takes priority; a simultaneous read is dropped entirely.
          if (avs_write) begin
            state    <= WR_STROBE;
            addr_err <= mux_err;
            if (live_mode) begin
              csr_d_bit       <= avs_writedata[0];
              csr_bit_address <= live_bit;
              csr_load_bit_n  <= ~reg_onehot;
            end else begin
              csr_d_all      <= avs_writedata;
              csr_load_all_n <= ~reg_onehot;
            end
          end else if (avs_read) begin
            state    <= RD_CAPTURE;
            addr_err <= mux_err;
            lat_bit  <= live_bit;
            lat_reg  <= live_reg;
            lat_mode <= live_mode;
          end
        end
        WR_STROBE: begin
          state <= IDLE;
        end
        RD_CAPTURE: begin
          state             <= IDLE;
          avs_readdata      <= mux_word;
          avs_readdatavalid <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_bus_responder.sv
// Scoreboard bench for csr_bus_responder with a behavioural register bank
// (NUM_REGS=6 so that indices 6 and 7 are out of range).
module tb_csr_bus_responder;

  localparam int NUM_REGS = 6;
  localparam int WIDTH    = 32;
  localparam int RIDX_W   = 3;
  localparam int BIDX_W   = 5;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               issue;
    string            tag;
  } sb_entry_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [RIDX_W+BIDX_W:0]    avs_address;
  logic                      avs_read;
  logic                      avs_write;
  logic [WIDTH-1:0]          avs_writedata;
  logic                      avs_waitrequest;
  logic [WIDTH-1:0]          avs_readdata;
  logic                      avs_readdatavalid;
  logic [WIDTH-1:0]          csr_d_all;
  logic                      csr_d_bit;
  logic [BIDX_W-1:0]         csr_bit_address;
  logic [NUM_REGS-1:0]       csr_load_all_n;
  logic [NUM_REGS-1:0]       csr_load_bit_n;
  logic [NUM_REGS*WIDTH-1:0] csr_q_all;
  logic                      addr_err;

  logic [WIDTH-1:0] bank   [NUM_REGS];
  logic [WIDTH-1:0] shadow [NUM_REGS];
  logic             bank_clear;
  sb_entry_t        sb[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               last_issue = 0;
  int               rdv_cycles = 0;
  int               all_strobe_cycles = 0;
  int               bit_strobe_cycles = 0;
  int               multi_low_cycles = 0;
  int               addr_err_cycles = 0;

  csr_bus_responder #(
    .NUM_REGS(NUM_REGS),
    .WIDTH   (WIDTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .csr_d_all        (csr_d_all),
    .csr_d_bit        (csr_d_bit),
    .csr_bit_address  (csr_bit_address),
    .csr_load_all_n   (csr_load_all_n),
    .csr_load_bit_n   (csr_load_bit_n),
    .csr_q_all        (csr_q_all),
    .addr_err         (addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register bank driven by the responder's strobes.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bank_clear) bank[i] <= '0;
      else if (!csr_load_all_n[i]) bank[i] <= csr_d_all;
      else if (!csr_load_bit_n[i]) bank[i][csr_bit_address] <= csr_d_bit;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) csr_q_all[i*WIDTH +: WIDTH] = bank[i];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      rdv_cycles++;
      if (sb.size() == 0) begin
        checkOutput("rdv_unexpected", 1, 0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput({e.tag, "_data"}, avs_readdata, e.data);
        checkOutput({e.tag, "_latency"}, cyc - e.issue, 2);
      end
    end
    if (csr_load_all_n != '1) all_strobe_cycles++;
    if (csr_load_bit_n != '1) bit_strobe_cycles++;
    if ($countones(~csr_load_all_n) + $countones(~csr_load_bit_n) > 1) multi_low_cycles++;
    if (addr_err) addr_err_cycles++;
  end

  // Drives one request in an IDLE cycle and returns #1 after its acceptance edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic mode,
                               input logic [RIDX_W-1:0] ridx, input logic [BIDX_W-1:0] bidx,
                               input logic [WIDTH-1:0] wdata, input string tag);
    int guard;
    logic [WIDTH-1:0] expv;
    guard = 0;
    @(negedge clk);
    while (avs_waitrequest && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (avs_waitrequest) checkOutput({tag, "_wait_timeout"}, 1, 0);
    avs_address   = {mode, ridx, bidx};
    avs_read      = rd;
    avs_write     = wr;
    avs_writedata = wdata;
    last_issue    = cyc;
    if (wr) begin
      if (ridx < NUM_REGS) begin
        if (mode) shadow[ridx][bidx] = wdata[0];
        else shadow[ridx] = wdata;
      end
    end else if (rd) begin
      if (ridx >= NUM_REGS) expv = '0;
      else if (mode) expv = WIDTH'(shadow[ridx][bidx]);
      else expv = shadow[ridx];
      sb.push_back('{data: expv, issue: cyc, tag: tag});
    end
    @(posedge clk);
    #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic drainScoreboard(input string tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_drain"}, sb.size(), 0);
  endtask

  initial begin
    int s_all, s_bit, s_rdv, s_err, w_issue;
    logic [WIDTH-1:0] saved;
    reset = 1'b1;
    bank_clear = 1'b1;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    for (int i = 0; i < NUM_REGS; i++) shadow[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_waitreq", avs_waitrequest, 1);
    checkOutput("rst_readdata", avs_readdata, 0);
    checkOutput("rst_rdv", avs_readdatavalid, 0);
    checkOutput("rst_load_all_n", csr_load_all_n, 6'h3F);
    checkOutput("rst_load_bit_n", csr_load_bit_n, 6'h3F);
    checkOutput("rst_d_all", csr_d_all, 0);
    checkOutput("rst_bitaddr_dbit", {csr_bit_address, csr_d_bit}, 0);
    checkOutput("rst_addr_err", addr_err, 0);
    bank_clear = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("rel_waitreq", avs_waitrequest, 0);

    // Word write to reg 3, then read it back.
    s_all = all_strobe_cycles;
    applyStimulus(0, 1, 0, 3'd3, 5'd0, 32'hA5A5_0F0F, "wr3");
    checkOutput("wr3_load_all_n", csr_load_all_n, 6'b110111);
    checkOutput("wr3_load_bit_n", csr_load_bit_n, 6'h3F);
    checkOutput("wr3_d_all", csr_d_all, 32'hA5A5_0F0F);
    checkOutput("wr3_waitreq", avs_waitrequest, 1);
    checkOutput("wr3_addr_err", addr_err, 0);
    @(posedge clk); #1;
    checkOutput("wr3_strobe_off", csr_load_all_n, 6'h3F);
    checkOutput("wr3_d_all_hold", csr_d_all, 32'hA5A5_0F0F);
    checkOutput("wr3_strobe_cycles", all_strobe_cycles - s_all, 1);
    applyStimulus(1, 0, 0, 3'd3, 5'd0, 0, "rd3");
    drainScoreboard("rd3");

    // Bit write reg 5 bit 17 on a zeroed register.
    s_bit = bit_strobe_cycles;
    applyStimulus(0, 1, 1, 3'd5, 5'd17, 32'h1, "bw5");
    checkOutput("bw5_load_bit_n", csr_load_bit_n, 6'b011111);
    checkOutput("bw5_load_all_n", csr_load_all_n, 6'h3F);
    checkOutput("bw5_bit_address", csr_bit_address, 17);
    checkOutput("bw5_d_bit", csr_d_bit, 1);
    applyStimulus(1, 0, 0, 3'd5, 5'd0, 0, "rd5_word");
    applyStimulus(1, 0, 1, 3'd5, 5'd17, 0, "rd5_b17");
    applyStimulus(1, 0, 1, 3'd5, 5'd16, 0, "rd5_b16");
    drainScoreboard("rd5");
    checkOutput("bw5_strobe_cycles", bit_strobe_cycles - s_bit, 1);
    checkOutput("rd5_word_value", shadow[5], 32'h0002_0000);

    // Simultaneous read and write: write wins, read dropped.
    s_all = all_strobe_cycles;
    s_rdv = rdv_cycles;
    applyStimulus(1, 1, 0, 3'd1, 5'd0, 32'h1234, "rw1");
    checkOutput("rw1_load_all_n", csr_load_all_n, 6'b111101);
    repeat (4) @(negedge clk);
    checkOutput("rw1_no_rdv", rdv_cycles - s_rdv, 0);
    checkOutput("rw1_strobe_cycles", all_strobe_cycles - s_all, 1);
    applyStimulus(1, 0, 0, 3'd1, 5'd0, 0, "rd1");
    drainScoreboard("rd1");

    // Back-to-back write then read of reg 0.
    applyStimulus(0, 1, 0, 3'd0, 5'd0, 32'hDEAD_BEEF, "wr0");
    w_issue = last_issue;
    applyStimulus(1, 0, 0, 3'd0, 5'd0, 0, "b2b_rd0");
    checkOutput("b2b_issue_gap", last_issue - w_issue, 2);
    drainScoreboard("b2b");

    // Out-of-range accesses.
    s_all = all_strobe_cycles;
    s_bit = bit_strobe_cycles;
    s_err = addr_err_cycles;
    applyStimulus(0, 1, 0, 3'd7, 5'd0, 32'hFFFF_FFFF, "oor_wr7");
    checkOutput("oor_wr7_addr_err", addr_err, 1);
    checkOutput("oor_wr7_waitreq", avs_waitrequest, 1);
    repeat (3) @(negedge clk);
    checkOutput("oor_wr7_no_strobe", (all_strobe_cycles - s_all) + (bit_strobe_cycles - s_bit), 0);
    checkOutput("oor_wr7_err_pulses", addr_err_cycles - s_err, 1);
    s_err = addr_err_cycles;
    applyStimulus(1, 0, 0, 3'd6, 5'd0, 0, "oor_rd6");
    checkOutput("oor_rd6_addr_err", addr_err, 1);
    drainScoreboard("oor_rd6");
    checkOutput("oor_rd6_err_pulses", addr_err_cycles - s_err, 1);

    // Reset during WR_STROBE: strobe must vanish before the bank edge.
    applyStimulus(1, 0, 0, 3'd3, 5'd0, 0, "pre_rst_rd3");
    drainScoreboard("pre_rst");
    saved = shadow[2];
    applyStimulus(0, 1, 0, 3'd2, 5'd0, 32'h5555_AAAA, "rst_wr2");
    shadow[2] = saved;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_load_all_n", csr_load_all_n, 6'h3F);
    checkOutput("rst_mid_waitreq", avs_waitrequest, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_rel_waitreq", avs_waitrequest, 0);
    checkOutput("rst_rel_readdata", avs_readdata, 0);
    checkOutput("rst_rel_rdv", avs_readdatavalid, 0);

    // Reset during RD_CAPTURE cancels the pending readdatavalid.
    s_rdv = rdv_cycles;
    applyStimulus(1, 0, 0, 3'd3, 5'd0, 0, "cancel_rd3");
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("cancel_no_rdv", rdv_cycles - s_rdv, 0);

    // Mixed pseudo-random traffic, including out-of-range indices.
    for (int n = 0; n < 24; n++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 2));
      applyStimulus(kind != 2'd0, kind == 2'd0, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, "rnd");
    end
    drainScoreboard("rnd");
    applyStimulus(1, 0, 0, 3'd2, 5'd0, 0, "rd2_after_rst");
    drainScoreboard("rd2");
    checkOutput("one_strobe_max", multi_low_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
